// File: rtl/bram_sched_pkg.sv
// Purpose: shared types and helpers for the BRAM request scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bram_sched_pkg;

  // Scheduler phases: zero-fill sweep after reset, then normal service.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Next requester index in round-robin order, wrapping at n.
  function automatic int unsigned next_rr(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bram_req_scheduler_rr_arbiter.sv
// Purpose: round-robin arbiter; the last winner gets lowest priority next time.
// Latency: grant is combinational in the request cycle; pointer moves on the edge.
// Backpressure: a requester holds its request until it sees its grant bit.
module rr_arbiter
  import bram_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Scan from pointer+1 upward (wrapping) and grant the first active request.
  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'(next_rr(32'(idx), NUM_REQ));
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = idx;
      end
    end
  end

  // Pointer starts at the last requester so requester 0 wins first after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= PW'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bram_req_scheduler.sv
// Purpose: shares one BRAM read port among NUM_REQ requesters, owns the write port, zero-fills after reset.
// Latency: read grant same cycle, response strobe one cycle later; writes pass through combinationally.
// Backpressure: requesters hold until granted; writes never stall reads. Optional macro: BRAM_SCHED_WR_BYPASS_EN.
module bram_req_scheduler
  import bram_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LO         = 0,
  parameter int unsigned HI         = 255
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            RD_REQ,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] RD_ADDR,
  output logic [NUM_REQ-1:0]            RD_GNT,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  output logic [DATA_WIDTH-1:0]         RSP_DATA,
  input  logic                          WR_REQ,
  input  logic [ADDR_WIDTH-1:0]         WR_ADDR,
  input  logic [DATA_WIDTH-1:0]         WR_VAL,
  output logic                          WR_GNT,
  output logic                          INIT_DONE,
  output logic                          BRAM_RD_EN,
  output logic [ADDR_WIDTH-1:0]         BRAM_RD_ADDR,
  input  logic [DATA_WIDTH-1:0]         BRAM_DOUT,
  input  logic                          BRAM_DOUT_RDY,
  output logic                          BRAM_WR_EN,
  output logic [ADDR_WIDTH-1:0]         BRAM_WR_ADDR,
  output logic [DATA_WIDTH-1:0]         BRAM_WR_VAL
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      gnt;
  logic [NUM_REQ-1:0]      tag_q;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    run;

  assign run = (state_q == RUN);

  // Sweep counter walks LO..HI once, then the FSM parks in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_WIDTH'(HI)) begin
        state_d = RUN;
      end
    end
  end

  // FSM, sweep counter and the in-flight response tag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= INIT;
      cnt_q   <= ADDR_WIDTH'(LO);
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= gnt;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i (CLK),
    .rst_i (RST),
    .req_i (RD_REQ),
    .en_i  (run),
    .gnt_o (gnt)
  );

  assign RD_GNT     = gnt;
  assign BRAM_RD_EN = |gnt;
  assign BRAM_RD_ADDR = rd_addr;
  assign INIT_DONE  = run;

  // Select the winning requester's address (grant is one-hot or zero).
  always_comb begin
    rd_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        rd_addr = RD_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Write port: zero-fill during the sweep, client pass-through afterwards.
  always_comb begin
    WR_GNT       = 1'b0;
    BRAM_WR_EN   = 1'b0;
    BRAM_WR_ADDR = '0;
    BRAM_WR_VAL  = '0;
    if (!run) begin
      BRAM_WR_EN   = 1'b1;
      BRAM_WR_ADDR = cnt_q;
    end else begin
      WR_GNT       = WR_REQ;
      BRAM_WR_EN   = WR_REQ;
      BRAM_WR_ADDR = WR_ADDR;
      BRAM_WR_VAL  = WR_VAL;
    end
  end

  // Response strobe goes only to the requester granted last cycle.
  assign RSP_VALID = BRAM_DOUT_RDY ? tag_q : '0;

`ifdef BRAM_SCHED_WR_BYPASS_EN
  logic                  byp_hit_q;
  logic [DATA_WIDTH-1:0] byp_val_q;

  // Remember whether this cycle's read collides with this cycle's accepted write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      byp_hit_q <= 1'b0;
    end else begin
      byp_hit_q <= run && WR_REQ && (|gnt) && (WR_ADDR == rd_addr);
    end
    byp_val_q <= WR_VAL;
  end

  assign RSP_DATA = byp_hit_q ? byp_val_q : BRAM_DOUT;
`else
  // BRAM returns pre-write data on a same-address collision.
  assign RSP_DATA = BRAM_DOUT;
`endif

endmodule

// File: tb/tb_bram_req_scheduler.sv
// Purpose: self-checking bench for bram_req_scheduler with a behavioural BRAM and reference model.
// Latency: model predicts grant same cycle, response one cycle later.
// Backpressure: random DOUT_RDY drops exercise the response-strobe gating.
module tb_bram_req_scheduler;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LO = 0;
  localparam int HI = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NR-1:0]    rd_req;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_gnt, rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             wr_req;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_val;
  logic             wr_gnt, init_done;
  logic             bram_rd_en, bram_wr_en;
  logic [AW-1:0]    bram_rd_addr, bram_wr_addr;
  logic [DW-1:0]    bram_wr_val;
  logic [DW-1:0]    env_dout = '0;
  logic             env_rdy  = 1'b0;
  logic             rdy_kill;
  logic             env_filled = 1'b0;
  logic [DW-1:0]    env_mem [256];

  bram_req_scheduler #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LO(LO), .HI(HI)
  ) dut (
    .CLK(clk), .RST(rst),
    .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_GNT(rd_gnt),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
    .WR_REQ(wr_req), .WR_ADDR(wr_addr), .WR_VAL(wr_val), .WR_GNT(wr_gnt),
    .INIT_DONE(init_done),
    .BRAM_RD_EN(bram_rd_en), .BRAM_RD_ADDR(bram_rd_addr),
    .BRAM_DOUT(env_dout), .BRAM_DOUT_RDY(env_rdy & ~rdy_kill),
    .BRAM_WR_EN(bram_wr_en), .BRAM_WR_ADDR(bram_wr_addr), .BRAM_WR_VAL(bram_wr_val)
  );

  // Behavioural BRAM: one-cycle read latency, read-before-write, preloaded with non-zero content.
  always @(posedge clk) begin
    if (!env_filled) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 32'hC0DE_0000 | 32'(i);
      env_filled <= 1'b1;
    end else begin
      if (bram_rd_en) env_dout <= env_mem[bram_rd_addr];
      env_rdy <= bram_rd_en;
      if (bram_wr_en) env_mem[bram_wr_addr] <= bram_wr_val;
    end
  end

  // Reference model state
  bit            m_init;
  int            m_cnt, m_ptr;
  logic [NR-1:0] m_pend;
  logic [DW-1:0] m_pend_dat;
  logic [DW-1:0] ref_mem [256];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge against the model, advance the model, return at posedge+1.
  task automatic cycle();
    int            c;
    logic [NR-1:0] eg;
    logic [AW-1:0] ra;
    @(negedge clk);
    if (rst) begin
      m_init = 1; m_cnt = LO; m_ptr = NR - 1; m_pend = '0;
    end else begin
      chk("rsp_valid", rsp_valid, (m_pend != 0 && !rdy_kill) ? m_pend : '0);
      if (m_pend != 0 && !rdy_kill) chk("rsp_data", rsp_data, m_pend_dat);
      chk("init_done", init_done, !m_init);
      eg = '0;
      if (m_init) begin
        chk("gnt_in_sweep", rd_gnt, '0);
        chk("rd_en_in_sweep", bram_rd_en, 0);
        chk("wr_gnt_in_sweep", wr_gnt, 0);
        chk("sweep_wr_en", bram_wr_en, 1);
        chk("sweep_wr_addr", bram_wr_addr, m_cnt);
        chk("sweep_wr_val", bram_wr_val, 0);
        ref_mem[m_cnt] = '0;
        m_pend = '0;
        if (m_cnt == HI) m_init = 0;
        m_cnt++;
      end else begin
        c = -1;
        for (int k = 1; k <= NR; k++)
          if (c < 0 && rd_req[(m_ptr + k) % NR]) c = (m_ptr + k) % NR;
        if (c >= 0) eg[c] = 1'b1;
        chk("rd_gnt", rd_gnt, eg);
        chk("rd_en", bram_rd_en, c >= 0);
        chk("wr_gnt", wr_gnt, wr_req);
        chk("wr_en", bram_wr_en, wr_req);
        if (wr_req) begin
          chk("wr_addr", bram_wr_addr, wr_addr);
          chk("wr_val", bram_wr_val, wr_val);
        end
        m_pend = eg;
        if (c >= 0) begin
          ra = rd_addr[c*AW +: AW];
          chk("rd_addr", bram_rd_addr, ra);
          m_pend_dat = ref_mem[ra];
`ifdef BRAM_SCHED_WR_BYPASS_EN
          if (wr_req && wr_addr == ra) m_pend_dat = wr_val;
`endif
          m_ptr = c;
        end
        if (wr_req) ref_mem[wr_addr] = wr_val;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NR*AW-1:0] addrs(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000 | 32'(i);
    rst = 1; rd_req = '0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_val = '0; rdy_kill = 0;
    cycle(); cycle();
    rst = 0;

    // Sweep: 8 zero writes then INIT_DONE; requests held high must not be granted.
    rd_req = '1; rd_addr = addrs(1, 2, 3, 4);
    #1;
    chk("reset_wr_addr", bram_wr_addr, LO);
    chk("reset_done", init_done, 0);
    for (int i = 0; i < HI - LO + 1; i++) cycle();
    chk("done_after_sweep", init_done, 1);

    // Full load: grants rotate 0,1,2,3,0,...
    for (int i = 0; i < 8; i++) begin
      chk("rr_full_load", rd_gnt, 4'b0001 << (i % NR));
      cycle();
    end
    rd_req = '0;
    cycle();

    // Write 0xA5 to 3, then requester 2 reads 3.
    wr_req = 1; wr_addr = 3; wr_val = 32'hA5;
    cycle();
    wr_req = 0; rd_req = 4'b0100; rd_addr = addrs(0, 0, 3, 0);
    cycle();
    chk("t3_rsp_valid", rsp_valid, 4'b0100);
    chk("t3_rsp_data", rsp_data, 32'hA5);

    // Same-cycle write and read of address 5.
    rd_req = 4'b0001; rd_addr = addrs(5, 0, 0, 0);
    wr_req = 1; wr_addr = 5; wr_val = 32'h11;
    cycle();
`ifdef BRAM_SCHED_WR_BYPASS_EN
    chk("t4_collision_data", rsp_data, 32'h11);
`else
    chk("t4_collision_data", rsp_data, 32'h0);
`endif
    wr_req = 0;

    // Pointer to 1, then requesters 1 and 3 alternate 3,1,3,1.
    rd_req = 4'b0010;
    cycle();
    rd_req = 4'b1010; rd_addr = addrs(0, 6, 0, 7);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_gnt", rd_gnt, (i % 2 == 0) ? 4'b1000 : 4'b0010);
      cycle();
    end

    // Reset in the cycle after a grant drops the in-flight response.
    rd_req = '1;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    chk("t6_rsp_valid", rsp_valid, '0);
    chk("t6_init_done", init_done, 0);
    chk("t6_sweep_addr", bram_wr_addr, LO);
    for (int i = 0; i < HI - LO + 2; i++) cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rd_req   = NR'($urandom);
      for (int r = 0; r < NR; r++) rd_addr[r*AW +: AW] = AW'($urandom_range(0, 15));
      wr_req   = ($urandom_range(0, 2) == 0);
      wr_addr  = AW'($urandom_range(0, 15));
      wr_val   = $urandom;
      rdy_kill = ($urandom_range(0, 7) == 0);
      cycle();
    end
    rd_req = '0; wr_req = 0; rdy_kill = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_req_scheduler.md
# bram_req_scheduler

Front-end controller for the triple-read/single-write block RAM. It shares one BRAM read port among `NUM_REQ` requesters with round-robin arbitration and routes each 1-cycle-latency read response back to its owner. It owns the BRAM write port: after reset it runs a zero-fill sweep over every entry, then passes one client's writes through. It sits between the timing-model clients and the BRAM instance; one scheduler is instantiated per BRAM read port used.

## Interface
Parameters:
- `NUM_REQ`, 4: number of read requesters (2..16).
- `ADDR_WIDTH`, 8: BRAM address width.
- `DATA_WIDTH`, 32: BRAM data width.
- `LO`, 0: first BRAM index.
- `HI`, 255: last BRAM index (inclusive).

Ports:
- `CLK`  in  1  clock; all logic rises on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `RD_REQ`  in  NUM_REQ  per-requester read request.
- `RD_ADDR`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `RD_GNT`  out  NUM_REQ  one-hot grant, combinational, same cycle as request.
- `RSP_VALID`  out  NUM_REQ  one-hot response strobe.
- `RSP_DATA`  out  DATA_WIDTH  response data, shared by all requesters.
- `WR_REQ`  in  1  client write request.
- `WR_ADDR`  in  ADDR_WIDTH  client write address.
- `WR_VAL`  in  DATA_WIDTH  client write data.
- `WR_GNT`  out  1  write accepted this cycle.
- `INIT_DONE`  out  1  zero-fill sweep complete.
- `BRAM_RD_EN`  out  1  BRAM read enable.
- `BRAM_RD_ADDR`  out  ADDR_WIDTH  BRAM read address.
- `BRAM_DOUT`  in  DATA_WIDTH  BRAM read data.
- `BRAM_DOUT_RDY`  in  1  BRAM read data valid.
- `BRAM_WR_EN`  out  1  BRAM write enable.
- `BRAM_WR_ADDR`  out  ADDR_WIDTH  BRAM write address.
- `BRAM_WR_VAL`  out  DATA_WIDTH  BRAM write data.

## Operation
- FSM states: `INIT` and `RUN`. Reset forces `INIT`, sets the sweep counter to `LO`, and sets the round-robin pointer to `NUM_REQ-1`, so requester 0 has top priority first.
- In `INIT`:
  - Each cycle: `BRAM_WR_EN`=1, `BRAM_WR_ADDR`=counter, `BRAM_WR_VAL`=0; the counter then increments.
  - At counter == `HI` the FSM moves to `RUN` on the next edge.
  - All of `RD_GNT`, `WR_GNT`, `BRAM_RD_EN` and `INIT_DONE` are 0.
- In `RUN`:
  - `INIT_DONE`=1.
  - Grant goes to the first requester with `RD_REQ` set, scanning pointer+1, pointer+2, … modulo `NUM_REQ`.
  - On a grant: `BRAM_RD_EN`=1, `BRAM_RD_ADDR`=the winner's address, and the pointer updates to the winner on the edge.
  - No request: pointer holds and `BRAM_RD_EN`=0.
- Response routing:
  - The grant vector is registered as `tag_q`.
  - `RSP_VALID` = `tag_q` when `BRAM_DOUT_RDY`=1, else 0.
  - `RSP_DATA` = `BRAM_DOUT`.
- Writes in `RUN`: `WR_GNT`=`WR_REQ`. The BRAM write port is driven straight from `WR_ADDR`/`WR_VAL` with `BRAM_WR_EN`=`WR_REQ`. A write never stalls a read.
- Same-address read and write in one cycle returns the old data unless bypass is enabled (see Configuration).
- Reset mid-operation:
  - `tag_q` clears, so a response in flight is dropped: `RSP_VALID`=0 in the cycle after `RST`.
  - The sweep restarts at `LO`.

## Timing
- Reset values: `RD_GNT`=0, `RSP_VALID`=0, `WR_GNT`=0, `INIT_DONE`=0, `BRAM_RD_EN`=0. During the first `INIT` cycle the write outputs are `BRAM_WR_EN`=1, `BRAM_WR_ADDR`=`LO`, `BRAM_WR_VAL`=0.
- Sweep duration: `HI-LO+1` cycles. `INIT_DONE` rises on the cycle after the write to `HI`.
- Read latency: grant in cycle t, `RSP_VALID` in cycle t+1. Sustained throughput is one read per cycle.
- A requester holds `RD_REQ`/`RD_ADDR` until it sees `RD_GNT`. A new request from the same requester may be issued in cycle t+1.
- Fairness: under full load, each requester is granted exactly once per `NUM_REQ` cycles.

## Configuration
- `BRAM_SCHED_WR_BYPASS_EN` defined:
  - A registered compare checks whether cycle t's read address equals cycle t's accepted write address.
  - On a match, `RSP_DATA` in t+1 is the registered `WR_VAL` instead of `BRAM_DOUT`.
- `BRAM_SCHED_WR_BYPASS_EN` undefined: no compare logic; `RSP_DATA`=`BRAM_DOUT` always (old-data semantics).

## Structure
- Package `bram_sched_pkg`: FSM state enum (`INIT`, `RUN`) and a `next_rr` index helper function.
- Sub-module `rr_arbiter` (`NUM_REQ` parameter):
  - Inputs: request vector, enable.
  - Outputs: one-hot grant.
  - Owns the pointer register.
- The top level holds the FSM, sweep counter, `tag_q`, the address mux and the optional bypass registers.

## Test plan
1. Reset, `LO`=0, `HI`=7 → `BRAM_WR_EN` high for 8 cycles with addresses 0..7 and data 0; `INIT_DONE`=1 in cycle 9; no grants during the sweep.
2. `RUN`, `NUM_REQ`=4, all `RD_REQ` held high → grants 0,1,2,3,0,… one per cycle; `RSP_VALID` follows one cycle later with matching one-hot.
3. Write `0xA5` to address 3, next cycle requester 2 reads address 3 → `RD_GNT`=0100, then `RSP_VALID`=0100 with `RSP_DATA`=`0xA5`.
4. Same-cycle write `0x11` and read, both to address 5, prior content 0:
   - With bypass: `RSP_DATA`=`0x11`.
   - Without bypass: `RSP_DATA`=0.
5. Only requesters 1 and 3 requesting, with the pointer at 1 → grants 3,1,3,1; requesters 0 and 2 never granted.
6. Assert `RST` in the cycle after a grant → `RSP_VALID`=0 in the following cycle; sweep restarts at `LO`; `INIT_DONE` drops to 0.
